instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter IW, default 10, instruction width in bits.
REQ-002 Parameter CW, default 8, retired-instruction counter width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port instr_in, input, IW, instruction word; opcode = instr_in[3:0].
REQ-007 Port instr_valid, input, 1, instr_in holds a valid instruction.
REQ-008 Port instr_ready, output, 1, sequencer accepts instr_in this cycle.
REQ-009 Port halt, input, 1, blocks acceptance of new instructions.
REQ-010 Port stall, input, 1, freezes the timestep of an executing instruction.
REQ-011 Port clr_err, input, 1, clears illegal_err.
REQ-012 Port ir, output, IW, latched instruction driven to the controller.
REQ-013 Port T, output, 2, current timestep to the controller.
REQ-014 Port busy, output, 1, instruction in flight (T1..T3).
REQ-015 Port done, output, 1, instruction retires this cycle.
REQ-016 Port illegal_err, output, 1, sticky illegal-opcode flag.
REQ-017 Port retired, output, CW, count of retired instructions.

Function
REQ-018 The FSM SHALL have states FETCH (T=00), EX1 (T=01), EX2 (T=10), EX3 (T=11); T is a direct encoding of the state.
REQ-019 instr_ready SHALL equal (state==FETCH) & !halt; busy SHALL equal state!=FETCH.
REQ-020 Handshake: when instr_valid & instr_ready at a clock edge, ir <= instr_in and state <= EX1; otherwise FETCH is held and ir is unchanged.
REQ-021 ir SHALL change only on an accepted handshake.
REQ-022 In EX1 with opcode 0 (LOAD) or 1 (COPY) and !stall, done SHALL be 1 and the next state SHALL be FETCH (two-cycle instruction).
REQ-023 In EX1 with opcode 2..13 and !stall, the next state SHALL be EX2; EX2 with !stall SHALL go to EX3.
REQ-024 In EX3 with !stall, done SHALL be 1 and the next state SHALL be FETCH (four-cycle instruction).
REQ-025 Opcodes 14 and 15 are illegal: in EX1 with !stall, illegal_err SHALL be set, done SHALL stay 0, retired SHALL not increment, and the next state SHALL be FETCH.
REQ-026 stall=1 in EX1/EX2/EX3 SHALL hold state, T, and ir, and force done=0; stall SHALL be ignored in FETCH.
REQ-027 halt SHALL have no effect on an instruction already in EX1..EX3.
REQ-028 done SHALL be combinational from state, opcode, and stall, and SHALL be high for exactly one cycle per retired instruction.
REQ-029 retired SHALL increment by 1 on each cycle with done=1 and wrap from 2^CW-1 to 0.
REQ-030 illegal_err SHALL stay set until a cycle with clr_err=1; if clr_err and a new illegal detection coincide, illegal_err SHALL be 1.
REQ-031 Back-to-back: instr_ready SHALL be 0 in the retiring cycle; the earliest next acceptance is the following FETCH cycle.

Reset
REQ-032 While rst_n=0, regardless of clk: state=FETCH (T=00), ir=0, retired=0, illegal_err=0.
REQ-033 Reset asserted mid-instruction SHALL abort it with no done and no retired increment.
REQ-034 After rst_n deasserts, the first handshake SHALL be accepted at the first rising edge with instr_valid=1 and halt=0.

Verification
REQ-035 Accept ADD 0x002 -> T sequence 00,01,10,11; done=1 only in T=11; retired 0->1; then T=00 with instr_ready=1.
REQ-036 Accept LOAD 0x040 -> T 00,01; done=1 in T=01; ir=0x040; next cycle T=00.
REQ-037 Accept SUB, hold stall=1 for 3 cycles in EX2 -> T stays 10 for 3 cycles, done=0; then 11, done=1.
REQ-038 Accept opcode 0x00F -> illegal_err=1 after EX1, done never 1, retired unchanged; clr_err pulse -> illegal_err=0.
REQ-039 halt=1 with instr_valid=1 in FETCH -> instr_ready=0, no acceptance; halt raised in EX2 -> instruction still retires.
REQ-040 Preload retired=255 (255 retirements), retire one more -> retired=0; rst_n pulled low in EX2 -> T=00, retired=0 immediately.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: latches an instruction on a valid/ready handshake,
// then walks the controller through timesteps T1..T3. LOAD/COPY finish in T1,
// other legal opcodes finish in T3, and opcodes 14/15 raise a sticky error flag.
module instr_sequencer #(
    parameter int IW = 10,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] instr_in,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          halt,
    input  logic          stall,
    input  logic          clr_err,
    output logic [IW-1:0] ir,
    output logic [1:0]    T,
    output logic          busy,
    output logic          done,
    output logic          illegal_err,
    output logic [CW-1:0] retired
);

    // The state encoding doubles as the timestep value seen by the controller.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EX1   = 2'b01,
        EX2   = 2'b10,
        EX3   = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [IW-1:0] r_ir;
    logic [CW-1:0] r_retired;
    logic          r_illegalErr;
    logic [3:0]    w_opcode;
    logic          w_accept;
    logic          w_done;
    logic          w_illegalDet;

    assign w_opcode    = r_ir[3:0];
    assign ir          = r_ir;
    assign T           = r_state;
    assign busy        = (r_state != FETCH);
    assign instr_ready = (r_state == FETCH) && !halt;
    assign done        = w_done;
    assign illegal_err = r_illegalErr;
    assign retired     = r_retired;

    // Next-state decode, retire pulse and illegal-opcode detection.
    always_comb begin
        w_nextState  = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_illegalDet = 1'b0;
        case (r_state)
            FETCH: begin
                if (instr_valid && !halt) begin
                    w_accept    = 1'b1;
                    w_nextState = EX1;
                end
            end
            EX1: begin
                if (!stall) begin
                    if (w_opcode >= 4'd14) begin
                        w_illegalDet = 1'b1;
                        w_nextState  = FETCH;
                    end else if (w_opcode <= 4'd1) begin
                        w_done      = 1'b1;
                        w_nextState = FETCH;
                    end else begin
                        w_nextState = EX2;
                    end
                end
            end
            EX2: begin
                if (!stall) begin
                    w_nextState = EX3;
                end
            end
            EX3: begin
                if (!stall) begin
                    w_done      = 1'b1;
                    w_nextState = FETCH;
                end
            end
            default: w_nextState = FETCH;
        endcase
    end

    // State, instruction register, retire counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_ir         <= '0;
            r_retired    <= '0;
            r_illegalErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_ir <= instr_in;
            end
            if (w_done) begin
                r_retired <= r_retired + CW'(1);
            end
            if (w_illegalDet) begin
                r_illegalErr <= 1'b1;
            end else if (clr_err) begin
                r_illegalErr <= 1'b0;
            end
        end
    end

endmodule
